// File: rtl/dds_sweep_pkg.sv
// rtl/dds_sweep_pkg.sv - shared widths and state encoding for the DDS sweep sequencer (DDS_SWEEP_BIDIR_EN adds direction)
package dds_sweep_pkg;
  localparam int FW = 32;
  localparam int PW = 12;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sweep_state_t;

`ifdef DDS_SWEEP_BIDIR_EN
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } sweep_dir_t;
`endif
endpackage

// File: rtl/dds_dwell_timer.sv
// rtl/dds_dwell_timer.sv - per-point dwell counter with load, decrement and zero flag
module dds_dwell_timer #(
  parameter int DW = dds_sweep_pkg::DW
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);
  logic [DW-1:0] cnt;

  always_ff @(posedge sclk) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - DW'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - DDS frequency-sweep sequencer; DDS_SWEEP_BIDIR_EN enables an up-then-down sweep
module dds_sweep_ctrl #(
  parameter int FW = dds_sweep_pkg::FW,
  parameter int PW = dds_sweep_pkg::PW,
  parameter int DW = dds_sweep_pkg::DW
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [FW-1:0] cfg_f_start,
  input  logic [FW-1:0] cfg_f_stop,
  input  logic [FW-1:0] cfg_f_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [PW-1:0] cfg_phase,
  input  logic          start,
  input  logic          abort,
  output logic [FW-1:0] freq_ctrl,
  output logic [PW-1:0] phase_ctrl,
  output logic          dds_en,
  output logic          busy,
  output logic          step_stb,
  output logic          sweep_done
);
  import dds_sweep_pkg::*;

  sweep_state_t  state, state_nx;
  logic          cfg_loaded;
  logic [FW-1:0] sh_f_start, sh_f_stop, sh_f_step;
  logic [DW-1:0] sh_dwell;
  logic [PW-1:0] sh_phase;
  // Active copy: a config accepted on the start edge must not disturb the sweep it launches.
  logic [FW-1:0] act_start, act_stop, act_step;
  logic [DW-1:0] act_dwell;
  logic          act_load;

  logic [FW-1:0] freq_nx;
  logic [PW-1:0] phase_nx;
  logic          en_nx, busy_nx, stb_nx, done_nx, ready_nx;
  logic          tmr_load, tmr_dec, tmr_zero;
  logic [DW-1:0] tmr_val;

  logic [FW:0]   up_sum;
  logic [FW-1:0] up_next, dn_next;
  assign up_sum  = {1'b0, freq_ctrl} + {1'b0, act_step};
  assign up_next = (up_sum >= {1'b0, act_stop}) ? act_stop : up_sum[FW-1:0];
  assign dn_next = ({1'b0, freq_ctrl} < {1'b0, act_start} + {1'b0, act_step}) ?
                   act_start : freq_ctrl - act_step;

`ifdef DDS_SWEEP_BIDIR_EN
  sweep_dir_t dir, dir_nx;
`endif

  function automatic logic [DW-1:0] dwell_m1(input logic [DW-1:0] d);
    return (d == '0) ? '0 : d - DW'(1);
  endfunction

  dds_dwell_timer #(.DW(DW)) u_dwell (
    .sclk(sclk), .rst_n(rst_n), .load(tmr_load), .load_val(tmr_val),
    .dec(tmr_dec), .zero(tmr_zero)
  );

  always_ff @(posedge sclk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    freq_nx  = freq_ctrl;
    phase_nx = phase_ctrl;
    en_nx    = dds_en;
    busy_nx  = busy;
    stb_nx   = 1'b0;
    done_nx  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = dwell_m1(act_dwell);
    tmr_dec  = (state == ST_RUN);
    act_load = 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
    dir_nx   = dir;
`endif
    case (state)
      ST_IDLE: begin
        if (start && cfg_loaded) begin
          state_nx = ST_RUN;
          freq_nx  = sh_f_start;
          phase_nx = sh_phase;
          en_nx    = 1'b1;
          busy_nx  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = dwell_m1(sh_dwell);
          act_load = 1'b1;
`ifdef DDS_SWEEP_BIDIR_EN
          dir_nx   = DIR_UP;
`endif
        end
      end
      ST_RUN: begin
        if (tmr_zero) begin
`ifdef DDS_SWEEP_BIDIR_EN
          if (dir == DIR_DOWN) begin
            if (freq_ctrl == act_start) begin
              state_nx = ST_DONE;
            end else begin
              freq_nx = dn_next; stb_nx = 1'b1; tmr_load = 1'b1;
            end
          end else if (act_start >= act_stop) begin
            state_nx = ST_DONE;
          end else if (act_step == '0) begin
            state_nx = ST_RUN;
          end else if (freq_ctrl == act_stop) begin
            dir_nx = DIR_DOWN; freq_nx = dn_next; stb_nx = 1'b1; tmr_load = 1'b1;
          end else begin
            freq_nx = up_next; stb_nx = 1'b1; tmr_load = 1'b1;
          end
`else
          if (freq_ctrl == act_stop || act_start >= act_stop) begin
            state_nx = ST_DONE;
          end else if (act_step != '0) begin
            freq_nx = up_next; stb_nx = 1'b1; tmr_load = 1'b1;
          end
`endif
          if (state_nx == ST_DONE) begin
            en_nx   = 1'b0;
            busy_nx = 1'b0;
            done_nx = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // Abort wins over every transition; freq/phase simply hold.
    if (abort) begin
      state_nx = ST_IDLE;
      freq_nx  = freq_ctrl;
      phase_nx = phase_ctrl;
      en_nx    = 1'b0;
      busy_nx  = 1'b0;
      stb_nx   = 1'b0;
      done_nx  = 1'b0;
      tmr_load = 1'b0;
      act_load = 1'b0;
    end
    ready_nx = (state_nx == ST_IDLE);
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      freq_ctrl  <= '0;
      phase_ctrl <= '0;
      dds_en     <= 1'b0;
      busy       <= 1'b0;
      step_stb   <= 1'b0;
      sweep_done <= 1'b0;
      cfg_ready  <= 1'b1;
      cfg_loaded <= 1'b0;
      sh_f_start <= '0;
      sh_f_stop  <= '0;
      sh_f_step  <= '0;
      sh_dwell   <= '0;
      sh_phase   <= '0;
      act_start  <= '0;
      act_stop   <= '0;
      act_step   <= '0;
      act_dwell  <= '0;
`ifdef DDS_SWEEP_BIDIR_EN
      dir        <= DIR_UP;
`endif
    end else begin
      freq_ctrl  <= freq_nx;
      phase_ctrl <= phase_nx;
      dds_en     <= en_nx;
      busy       <= busy_nx;
      step_stb   <= stb_nx;
      sweep_done <= done_nx;
      cfg_ready  <= ready_nx;
`ifdef DDS_SWEEP_BIDIR_EN
      dir        <= dir_nx;
`endif
      if (act_load) begin
        act_start <= sh_f_start;
        act_stop  <= sh_f_stop;
        act_step  <= sh_f_step;
        act_dwell <= sh_dwell;
      end
      if (cfg_valid && cfg_ready) begin
        sh_f_start <= cfg_f_start;
        sh_f_stop  <= cfg_f_stop;
        sh_f_step  <= cfg_f_step;
        sh_dwell   <= cfg_dwell;
        sh_phase   <= (cfg_phase >= PW'(360)) ? '0 : cfg_phase;
        cfg_loaded <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - scoreboard bench for dds_sweep_ctrl (honours DDS_SWEEP_BIDIR_EN)
module tb_dds_sweep_ctrl;
  localparam int FW = 32;
  localparam int PW = 12;
  localparam int DW = 16;

  logic          sclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [FW-1:0] cfg_f_start = '0, cfg_f_stop = '0, cfg_f_step = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic [PW-1:0] cfg_phase = '0;
  logic          start = 1'b0, abort = 1'b0;
  logic [FW-1:0] freq_ctrl;
  logic [PW-1:0] phase_ctrl;
  logic          dds_en, busy, step_stb, sweep_done;

  dds_sweep_ctrl dut (
    .sclk(sclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
    .cfg_dwell(cfg_dwell), .cfg_phase(cfg_phase), .start(start), .abort(abort),
    .freq_ctrl(freq_ctrl), .phase_ctrl(phase_ctrl), .dds_en(dds_en), .busy(busy),
    .step_stb(step_stb), .sweep_done(sweep_done)
  );

  always #5 sclk = ~sclk;

  typedef struct packed {
    logic [FW-1:0] f;
    logic          stb;
    logic          done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   pts[$];
  int   vectors = 0;
  int   miscompares = 0;

  always @(negedge sclk) begin
    if (dds_en || step_stb || sweep_done) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: freq=%0d en=%0b stb=%0b done=%0b, required no activity",
                 freq_ctrl, dds_en, step_stb, sweep_done);
      end else begin
        mon_e = sb.pop_front();
        if (freq_ctrl !== mon_e.f || step_stb !== mon_e.stb ||
            sweep_done !== mon_e.done || dds_en !== ~mon_e.done) begin
          miscompares++;
          $display("FAIL sweep_point: got freq=%0d en=%0b stb=%0b done=%0b, required freq=%0d en=%0b stb=%0b done=%0b",
                   freq_ctrl, dds_en, step_stb, sweep_done, mon_e.f, ~mon_e.done, mon_e.stb, mon_e.done);
        end
      end
    end
  end

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_one(input int f, input logic stb, input logic done);
    exp_t e;
    e.f = FW'(f);
    e.stb = stb;
    e.done = done;
    sb.push_back(e);
  endtask

  task automatic push_points(input int dwell);
    int hold;
    hold = (dwell == 0) ? 1 : dwell;
    foreach (pts[i])
      for (int d = 0; d < hold; d++)
        push_one(pts[i], (i > 0 && d == 0), 1'b0);
    push_one(pts[pts.size()-1], 1'b0, 1'b1);
  endtask

  task automatic load_cfg(input int fs, input int fe, input int st, input int dw, input int ph);
    cfg_f_start = FW'(fs);
    cfg_f_stop  = FW'(fe);
    cfg_f_step  = FW'(st);
    cfg_dwell   = DW'(dw);
    cfg_phase   = PW'(ph);
    cfg_valid   = 1'b1;
    tick;
    cfg_valid   = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick;
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d pending outputs, required 0", name, sb.size());
      sb.delete();
    end
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    tick;
    tick;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_dds_en", dds_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_freq", freq_ctrl, 0);
    chk("rst_phase", phase_ctrl, 0);
    chk("rst_step_stb", step_stb, 0);
    chk("rst_sweep_done", sweep_done, 0);
    rst_n = 1'b1;
    tick;

    pulse_start;
    tick;
    chk("start_without_cfg_en", dds_en, 0);
    chk("start_without_cfg_busy", busy, 0);

    load_cfg(1000, 1300, 100, 4, 90);
`ifdef DDS_SWEEP_BIDIR_EN
    pts = '{1000, 1100, 1200, 1300, 1200, 1100, 1000};
`else
    pts = '{1000, 1100, 1200, 1300};
`endif
    push_points(4);
    pulse_start;
    chk("t1_busy", busy, 1);
    chk("t1_cfg_ready", cfg_ready, 0);
    chk("t1_phase", phase_ctrl, 90);
    wait_drain("t1", 60);
    chk("t1_idle_ready", cfg_ready, 1);
    chk("t1_idle_busy", busy, 0);

    load_cfg(1000, 1250, 100, 2, 400);
`ifdef DDS_SWEEP_BIDIR_EN
    pts = '{1000, 1100, 1200, 1250, 1150, 1050, 1000};
`else
    pts = '{1000, 1100, 1200, 1250};
`endif
    push_points(2);
    pulse_start;
    chk("t2_phase_clip", phase_ctrl, 0);
    wait_drain("t2", 40);

    load_cfg(1000, 1300, 100, 4, 0);
    for (int i = 0; i < 4; i++) push_one(1000, 1'b0, 1'b0);
    push_one(1100, 1'b1, 1'b0);
    push_one(1100, 1'b0, 1'b0);
    pulse_start;
    repeat (5) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t3_abort_en", dds_en, 0);
    chk("t3_abort_busy", busy, 0);
    chk("t3_abort_ready", cfg_ready, 1);
    tick;
    tick;
    chk("t3_pending", sb.size(), 0);
    push_one(1000, 1'b0, 1'b0);
    pulse_start;
    chk("t3_retained_cfg_en", dds_en, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    tick;
    chk("t3_second_abort_en", dds_en, 0);

    load_cfg(1000, 1300, 0, 3, 0);
    for (int i = 0; i < 60; i++) push_one(1000, 1'b0, 1'b0);
    pulse_start;
    repeat (59) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    tick;
    chk("t4_tone_abort_en", dds_en, 0);
    chk("t4_pending", sb.size(), 0);

    load_cfg(1000, 1300, 100, 4, 0);
    for (int i = 0; i < 4; i++) push_one(1000, 1'b0, 1'b0);
    push_one(1100, 1'b1, 1'b0);
    push_one(1100, 1'b0, 1'b0);
    pulse_start;
    repeat (5) tick;
    rst_n = 1'b0;
    tick;
    chk("t5_rst_en", dds_en, 0);
    chk("t5_rst_freq", freq_ctrl, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", sweep_done, 0);
    chk("t5_rst_ready", cfg_ready, 1);
    rst_n = 1'b1;
    pulse_start;
    tick;
    chk("t5_start_ignored_en", dds_en, 0);
    chk("t5_start_ignored_busy", busy, 0);
    chk("t5_pending", sb.size(), 0);

    load_cfg(1000, 1200, 100, 1, 0);
`ifdef DDS_SWEEP_BIDIR_EN
    pts = '{1000, 1100, 1200, 1100, 1000};
`else
    pts = '{1000, 1100, 1200};
`endif
    push_points(1);
    cfg_f_start = FW'(2000);
    cfg_f_stop  = FW'(2000);
    cfg_f_step  = FW'(100);
    cfg_dwell   = '0;
    cfg_valid   = 1'b1;
    start       = 1'b1;
    tick;
    cfg_valid   = 1'b0;
    start       = 1'b0;
    wait_drain("t6_old_cfg", 30);
    pts = '{2000};
    push_points(0);
    pulse_start;
    wait_drain("t6_new_cfg", 10);
    chk("t6_final_ready", cfg_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
